// File: rtl/spi_mem_arb_pkg.sv
// Shared types and constants for the SPI memory arbiter: FSM encoding,
// master identifiers and default widths.
package spi_mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  localparam logic MID_IBUS = 1'b0;
  localparam logic MID_DBUS = 1'b1;

  localparam int DEF_AW    = 32;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/spi_mem_arb_pick.sv
// Combinational winner selection between ibus and dbus requests.
// SPI_MEM_ARB_RR_EN: round-robin on contention; otherwise dbus has fixed priority.
module spi_mem_arb_pick
  import spi_mem_arb_pkg::*;
(
  input  logic ibus_req_i,
  input  logic dbus_req_i,
`ifdef SPI_MEM_ARB_RR_EN
  input  logic last_i,
`endif
  output logic grant_o,
  output logic winner_o
);

  always_comb begin
    grant_o  = ibus_req_i | dbus_req_i;
    winner_o = MID_IBUS;
    if (ibus_req_i && dbus_req_i) begin
`ifdef SPI_MEM_ARB_RR_EN
      // The master that did not win last time takes this grant.
      winner_o = ~last_i;
`else
      winner_o = MID_DBUS;
`endif
    end else if (dbus_req_i) begin
      winner_o = MID_DBUS;
    end
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-master (ibus/dbus) arbiter in front of a Wishbone-to-SPI bridge.
// SPI_MEM_ARB_RR_EN selects round-robin instead of dbus fixed priority.
module spi_mem_arbiter
  import spi_mem_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [AW-1:0]    i_ibus_adr,
  input  logic             i_ibus_cyc,
  output logic [31:0]      o_ibus_rdt,
  output logic             o_ibus_ack,
  input  logic [AW-1:0]    i_dbus_adr,
  input  logic [31:0]      i_dbus_dat,
  input  logic [3:0]       i_dbus_sel,
  input  logic             i_dbus_we,
  input  logic             i_dbus_cyc,
  output logic [31:0]      o_dbus_rdt,
  output logic             o_dbus_ack,
  output logic [AW-1:0]    o_mem_adr,
  output logic [31:0]      o_mem_dat,
  output logic [3:0]       o_mem_sel,
  output logic             o_mem_we,
  output logic             o_mem_cyc,
  input  logic [31:0]      i_mem_rdt,
  input  logic             i_mem_ack,
  output logic [CNT_W-1:0] o_ibus_cnt,
  output logic [CNT_W-1:0] o_dbus_cnt,
  output logic             o_busy
);

  state_t             state_q, state_d;
  logic [AW-1:0]      adr_q, adr_d;
  logic [31:0]        dat_q, dat_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               cyc_q, cyc_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  logic [CNT_W-1:0]   dcnt_q, dcnt_d;
  logic               grant;
  logic               winner;

`ifdef SPI_MEM_ARB_RR_EN
  logic last_q, last_d;
`endif

  spi_mem_arb_pick u_pick (
    .ibus_req_i (i_ibus_cyc),
    .dbus_req_i (i_dbus_cyc),
`ifdef SPI_MEM_ARB_RR_EN
    .last_i     (last_q),
`endif
    .grant_o    (grant),
    .winner_o   (winner)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    icnt_d  = icnt_q;
    dcnt_d  = dcnt_q;
`ifdef SPI_MEM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          cyc_d = 1'b1;
`ifdef SPI_MEM_ARB_RR_EN
          last_d = winner;
`endif
          if (winner == MID_DBUS) begin
            state_d = S_BUSY_D;
            adr_d   = i_dbus_adr;
            dat_d   = i_dbus_dat;
            sel_d   = i_dbus_sel;
            we_d    = i_dbus_we;
            dcnt_d  = dcnt_q + CNT_W'(1);
          end else begin
            // Instruction fetches are always full-word reads.
            state_d = S_BUSY_I;
            adr_d   = i_ibus_adr;
            dat_d   = 32'd0;
            sel_d   = 4'b1111;
            we_d    = 1'b0;
            icnt_d  = icnt_q + CNT_W'(1);
          end
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        // The bridge transaction runs to completion even if the master left.
        if (i_mem_ack) begin
          state_d = S_GAP;
          adr_d   = '0;
          dat_d   = 32'd0;
          sel_d   = 4'd0;
          we_d    = 1'b0;
          cyc_d   = 1'b0;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      icnt_q  <= '0;
      dcnt_q  <= '0;
`ifdef SPI_MEM_ARB_RR_EN
      last_q  <= MID_IBUS;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      icnt_q  <= icnt_d;
      dcnt_q  <= dcnt_d;
`ifdef SPI_MEM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign o_mem_adr  = adr_q;
  assign o_mem_dat  = dat_q;
  assign o_mem_sel  = sel_q;
  assign o_mem_we   = we_q;
  assign o_mem_cyc  = cyc_q;
  assign o_ibus_cnt = icnt_q;
  assign o_dbus_cnt = dcnt_q;
  assign o_busy     = (state_q != S_IDLE);

  // Acks pass straight through, gated by owner and by the master still waiting.
  assign o_ibus_ack = i_mem_ack & (state_q == S_BUSY_I) & i_ibus_cyc;
  assign o_dbus_ack = i_mem_ack & (state_q == S_BUSY_D) & i_dbus_cyc;
  assign o_ibus_rdt = i_mem_rdt;
  assign o_dbus_rdt = i_mem_rdt;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed self-checking bench for spi_mem_arbiter (honours SPI_MEM_ARB_RR_EN).
module tb_spi_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic [31:0] o_ibus_rdt;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic [31:0] o_dbus_rdt;
  logic        o_dbus_ack;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic [7:0]  o_ibus_cnt;
  logic [7:0]  o_dbus_cnt;
  logic        o_busy;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  spi_mem_arbiter #(.AW(32), .CNT_W(8)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .o_mem_adr  (o_mem_adr),
    .o_mem_dat  (o_mem_dat),
    .o_mem_sel  (o_mem_sel),
    .o_mem_we   (o_mem_we),
    .o_mem_cyc  (o_mem_cyc),
    .i_mem_rdt  (i_mem_rdt),
    .i_mem_ack  (i_mem_ack),
    .o_ibus_cnt (o_ibus_cnt),
    .o_dbus_cnt (o_dbus_cnt),
    .o_busy     (o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_mem_cyc(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_mem_cyc === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    int         pulses;
    int         timeouts;
    logic [5:0] order;
    logic       exp_d;

    i_rst = 1'b1;
    i_ibus_adr = '0; i_ibus_cyc = 1'b0;
    i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
    i_mem_rdt = '0;  i_mem_ack = 1'b0;

    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst_mem_cyc", o_mem_cyc, 0);
    chk("rst_mem_adr", o_mem_adr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_icnt", o_ibus_cnt, 0);
    chk("rst_dcnt", o_dbus_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // dbus write, slow bridge ack
    i_dbus_adr = 32'h2e0; i_dbus_dat = 32'h12345678; i_dbus_sel = 4'b0100;
    i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    @(negedge i_clk);
    chk("dw_adr", o_mem_adr, 32'h2e0);
    chk("dw_dat", o_mem_dat, 32'h12345678);
    chk("dw_sel", o_mem_sel, 4'b0100);
    chk("dw_we", o_mem_we, 1);
    chk("dw_cyc", o_mem_cyc, 1);
    chk("dw_busy", o_busy, 1);
    chk("dw_dcnt", o_dbus_cnt, 1);
    i_dbus_adr = 32'h555; i_dbus_dat = 32'hdeadbeef; i_dbus_sel = 4'b0011;
    pulses = 0;
    repeat (39) begin
      @(negedge i_clk);
      if (o_dbus_ack === 1'b1) pulses++;
    end
    chk("dw_early_ack", pulses, 0);
    i_mem_ack = 1'b1; i_mem_rdt = 32'hcafe0001; i_ibus_cyc = 1'b1;
    #1;
    chk("dw_ack", o_dbus_ack, 1);
    chk("dw_ibus_ack_quiet", o_ibus_ack, 0);
    chk("dw_rdt", o_dbus_rdt, 32'hcafe0001);
    chk("dw_hold_adr", o_mem_adr, 32'h2e0);
    chk("dw_hold_sel", o_mem_sel, 4'b0100);
    @(negedge i_clk);
    i_mem_ack = 1'b0; i_dbus_cyc = 1'b0; i_ibus_cyc = 1'b0;
    #1;
    chk("dw_ack_once", o_dbus_ack, 0);
    chk("dw_clr_cyc", o_mem_cyc, 0);
    chk("dw_clr_adr", o_mem_adr, 0);
    chk("dw_clr_dat", o_mem_dat, 0);
    chk("dw_clr_sel", o_mem_sel, 0);
    chk("dw_clr_we", o_mem_we, 0);
    chk("dw_gap_busy", o_busy, 1);
    @(negedge i_clk);
    chk("dw_idle", o_busy, 0);

    // ibus read; dbus fields must not leak into an ibus grant
    i_ibus_adr = 32'h0; i_ibus_cyc = 1'b1; i_dbus_we = 1'b1;
    @(negedge i_clk);
    chk("ir_sel", o_mem_sel, 4'b1111);
    chk("ir_we", o_mem_we, 0);
    chk("ir_dat", o_mem_dat, 0);
    chk("ir_adr", o_mem_adr, 0);
    chk("ir_cyc", o_mem_cyc, 1);
    chk("ir_icnt", o_ibus_cnt, 1);
    repeat (3) @(negedge i_clk);
    i_mem_ack = 1'b1; i_mem_rdt = 32'h00340000;
    #1;
    chk("ir_ack", o_ibus_ack, 1);
    chk("ir_rdt", o_ibus_rdt, 32'h00340000);
    chk("ir_dbus_ack_quiet", o_dbus_ack, 0);
    @(negedge i_clk);
    #1;
    chk("gap_stray_ack", o_ibus_ack, 0);
    chk("gap_busy", o_busy, 1);
    @(negedge i_clk);
    #1;
    chk("idle_stray_ack", o_ibus_ack, 0);
    i_mem_ack = 1'b0; i_ibus_cyc = 1'b0;
    @(negedge i_clk);
    chk("ir_idle", o_busy, 0);

    // Contention for 6 grants
`ifdef SPI_MEM_ARB_RR_EN
    order = 6'b010101;
`else
    order = 6'b111111;
`endif
    i_ibus_adr = 32'h200; i_dbus_adr = 32'h100; i_dbus_we = 1'b0; i_dbus_sel = 4'hf;
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
    for (int g = 0; g < 6; g++) begin
      exp_d = order[g];
      wait_mem_cyc(ok);
      chk("arb_grant", ok, 1);
      chk("arb_adr", o_mem_adr, exp_d ? 32'h100 : 32'h200);
      i_mem_ack = 1'b1;
      #1;
      chk("arb_dack", o_dbus_ack, exp_d);
      chk("arb_iack", o_ibus_ack, !exp_d);
      @(negedge i_clk);
      i_mem_ack = 1'b0;
    end
    i_ibus_cyc = 1'b0; i_dbus_cyc = 1'b0;
`ifdef SPI_MEM_ARB_RR_EN
    chk("arb_icnt", o_ibus_cnt, 4);
    chk("arb_dcnt", o_dbus_cnt, 4);
`else
    chk("arb_icnt", o_ibus_cnt, 1);
    chk("arb_dcnt", o_dbus_cnt, 7);
`endif
    @(negedge i_clk);

    // ibus abandons its request mid-transaction
    i_ibus_adr = 32'h40; i_ibus_cyc = 1'b1;
    @(negedge i_clk);
    chk("ab_cyc", o_mem_cyc, 1);
    repeat (5) @(negedge i_clk);
    i_ibus_cyc = 1'b0;
    @(negedge i_clk);
    chk("ab_hold_cyc", o_mem_cyc, 1);
    chk("ab_hold_adr", o_mem_adr, 32'h40);
    i_mem_ack = 1'b1;
    #1;
    chk("ab_no_ack", o_ibus_ack, 0);
    @(negedge i_clk);
    i_mem_ack = 1'b0;
    chk("ab_gap_busy", o_busy, 1);
    chk("ab_gap_cyc", o_mem_cyc, 0);
    @(negedge i_clk);
    chk("ab_idle", o_busy, 0);

    // Reset during a dbus transaction
    i_dbus_adr = 32'h300; i_dbus_we = 1'b1; i_dbus_cyc = 1'b1;
    @(negedge i_clk);
    chk("rs_cyc", o_mem_cyc, 1);
    repeat (9) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("rs_mem_cyc", o_mem_cyc, 0);
    chk("rs_mem_adr", o_mem_adr, 0);
    chk("rs_busy", o_busy, 0);
    chk("rs_icnt", o_ibus_cnt, 0);
    chk("rs_dcnt", o_dbus_cnt, 0);
    i_dbus_cyc = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    i_dbus_cyc = 1'b1; i_mem_ack = 1'b1;
    #1;
    chk("rs_late_ack", o_dbus_ack, 0);
    #1;
    i_mem_ack = 1'b0; i_dbus_cyc = 1'b0;
    @(negedge i_clk);
    chk("rs_idle", o_busy, 0);

    // 256 ibus grants wrap the 8-bit counter
    i_ibus_adr = 32'h80; i_ibus_cyc = 1'b1;
    timeouts = 0;
    for (int i = 0; i < 256; i++) begin
      wait_mem_cyc(ok);
      if (!ok) timeouts++;
      i_mem_ack = 1'b1;
      @(negedge i_clk);
      i_mem_ack = 1'b0;
      if (i == 254) chk("wrap_255", o_ibus_cnt, 8'hff);
    end
    i_ibus_cyc = 1'b0;
    chk("wrap_timeouts", timeouts, 0);
    chk("wrap_icnt", o_ibus_cnt, 0);
    chk("wrap_dcnt", o_dbus_cnt, 0);
    @(negedge i_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
